// File: rtl/ppu_vram_port.sv
// PPU VRAM access port: $2000 increment select, $2002 toggle clear, $2006 address
// load, and $2007 data access with read buffering and the palette direct-read path.
module ppu_vram_port (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cpu_reg,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rvalid,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {IDLE, WR, RD, PAL2} state_e;

  state_e      state_q, state_d;
  logic [13:0] v_q, v_d;
  logic        w_q, w_d;
  logic        inc32_q, inc32_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;

  logic        wr, rd, ack, pal;
  logic [13:0] v_inc;

  // A combined read+write strobe counts as a write; acks outside a request are dropped.
  assign wr    = cpu_wr;
  assign rd    = cpu_rd & ~cpu_wr;
  assign ack   = req_q & mem_ack;
  assign pal   = (v_q[13:8] == 6'h3F);
  assign v_inc = v_q + (inc32_q ? 14'd32 : 14'd1);

  // Register updates and access sequencing; v is stable while busy, so pal is valid throughout.
  always_comb begin
    state_d  = state_q;
    v_d      = v_q;
    w_d      = w_q;
    inc32_d  = inc32_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    if (wr && cpu_reg == 3'd0) inc32_d = cpu_wdata[2];
    if (rd && cpu_reg == 3'd2) w_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr && cpu_reg == 3'd6) begin
          if (!w_q) begin
            v_d[13:8] = cpu_wdata[5:0];
            w_d       = 1'b1;
          end else begin
            v_d[7:0] = cpu_wdata;
            w_d      = 1'b0;
          end
        end else if (wr && cpu_reg == 3'd7) begin
          state_d = WR;
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = {2'b00, v_q};
          wdata_d = cpu_wdata;
        end else if (rd && cpu_reg == 3'd7) begin
          state_d = RD;
          req_d   = 1'b1;
          we_d    = 1'b0;
          addr_d  = {2'b00, v_q};
          if (!pal) begin
            rdata_d  = rbuf_q;
            rvalid_d = 1'b1;
          end
        end
      end
      WR: begin
        if (ack) begin
          v_d     = v_inc;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      RD: begin
        if (ack) begin
          if (pal) begin
            // Palette data goes straight out; the buffer is refilled from the nametable below.
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
            addr_d   = {2'b00, v_q[13], 1'b0, v_q[11:0]};
            state_d  = PAL2;
          end else begin
            rbuf_d  = mem_rdata;
            v_d     = v_inc;
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      PAL2: begin
        if (ack) begin
          rbuf_d  = mem_rdata;
          v_d     = v_inc;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset that also aborts any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      v_q      <= '0;
      w_q      <= 1'b0;
      inc32_q  <= 1'b0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      v_q      <= v_d;
      w_q      <= w_d;
      inc32_q  <= inc32_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign cpu_rdata  = rdata_q;
  assign cpu_rvalid = rvalid_q;
  assign busy       = (state_q != IDLE);
  assign mem_req    = req_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_ppu_vram_port.sv
// Directed bench for ppu_vram_port: hand-computed vectors, checked on the falling edge.
module tb_ppu_vram_port;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  cpu_reg = '0;
  logic        cpu_wr = 1'b0;
  logic        cpu_rd = 1'b0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  ppu_vram_port dut (
    .clk(clk), .rst(rst), .cpu_reg(cpu_reg), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [2:0] r, input logic [7:0] d);
    @(negedge clk);
    cpu_reg = r; cpu_wdata = d; cpu_wr = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [2:0] r);
    @(negedge clk);
    cpu_reg = r; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_rd = 1'b0;
  endtask

  // Called at a falling edge; returns one cycle later with the ack consumed.
  task automatic do_ack(input logic [7:0] d);
    mem_ack = 1'b1; mem_rdata = d;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    idle(2);
    chk("rst_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rvalid", cpu_rvalid, 0);
    chk("rst_rdata", cpu_rdata, 8'h00);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_we", mem_we, 0);
    chk("rst_wdata", mem_wdata, 8'h00);
    rst = 1'b0;

    // Address load and write
    cpu_write(3'd6, 8'h21);
    cpu_write(3'd6, 8'h08);
    cpu_write(3'd7, 8'h5A);
    chk("wr_req", mem_req, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 16'h2108);
    chk("wr_data", mem_wdata, 8'h5A);
    chk("wr_busy", busy, 1);
    idle(3);
    chk("wr_addr_hold", mem_addr, 16'h2108);
    chk("wr_data_hold", mem_wdata, 8'h5A);
    chk("wr_req_hold", mem_req, 1);
    do_ack(8'h00);
    chk("wr_req_drop", mem_req, 0);
    chk("wr_busy_drop", busy, 0);
    chk("wr_v", dut.v_q, 14'h2109);

    // Buffered read
    cpu_write(3'd6, 8'h20);
    cpu_write(3'd6, 8'h00);
    cpu_read(3'd7);
    chk("rd1_rvalid", cpu_rvalid, 1);
    chk("rd1_rdata", cpu_rdata, 8'h00);
    chk("rd1_addr", mem_addr, 16'h2000);
    chk("rd1_we", mem_we, 0);
    do_ack(8'hAB);
    chk("rd1_rvalid_low", cpu_rvalid, 0);
    cpu_read(3'd7);
    chk("rd2_rvalid", cpu_rvalid, 1);
    chk("rd2_rdata", cpu_rdata, 8'hAB);
    chk("rd2_addr", mem_addr, 16'h2001);
    do_ack(8'hCD);
    chk("rd2_v", dut.v_q, 14'h2002);
    chk("rd2_rdata_hold", cpu_rdata, 8'hAB);
    chk("rd2_rbuf", dut.rbuf_q, 8'hCD);

    // Palette read
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'h01);
    cpu_read(3'd7);
    chk("pal_no_rvalid", cpu_rvalid, 0);
    chk("pal_addr1", mem_addr, 16'h3F01);
    do_ack(8'h16);
    chk("pal_rvalid", cpu_rvalid, 1);
    chk("pal_rdata", cpu_rdata, 8'h16);
    chk("pal_req2", mem_req, 1);
    chk("pal_addr2", mem_addr, 16'h2F01);
    chk("pal_busy", busy, 1);
    idle(1);
    chk("pal_rvalid_low", cpu_rvalid, 0);
    do_ack(8'h77);
    chk("pal_rbuf", dut.rbuf_q, 8'h77);
    chk("pal_v", dut.v_q, 14'h3F02);
    chk("pal_done", busy, 0);
    chk("pal_rdata_hold", cpu_rdata, 8'h16);

    // Toggle and increment with wrap
    cpu_write(3'd6, 8'h3F);
    chk("tog_w1", dut.w_q, 1);
    cpu_read(3'd2);
    chk("tog_w0", dut.w_q, 0);
    cpu_write(3'd6, 8'h3F);
    cpu_write(3'd6, 8'hE0);
    chk("tog_v", dut.v_q, 14'h3FE0);
    cpu_write(3'd0, 8'h04);
    cpu_write(3'd7, 8'h11);
    chk("inc_addr", mem_addr, 16'h3FE0);
    do_ack(8'h00);
    chk("inc_wrap", dut.v_q, 14'h0000);

    // Write and read strobes together: write wins
    cpu_write(3'd0, 8'h00);
    @(negedge clk);
    cpu_reg = 3'd7; cpu_wdata = 8'h3C; cpu_wr = 1'b1; cpu_rd = 1'b1;
    @(negedge clk);
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    chk("both_we", mem_we, 1);
    chk("both_rvalid", cpu_rvalid, 0);
    do_ack(8'h00);
    chk("both_v", dut.v_q, 14'h0001);

    // Busy ignore and reset abort
    cpu_write(3'd7, 8'h55);
    idle(1);
    cpu_write(3'd7, 8'h66);
    chk("busy_wdata", mem_wdata, 8'h55);
    chk("busy_addr", mem_addr, 16'h0001);
    cpu_write(3'd6, 8'h12);
    chk("busy_w", dut.w_q, 0);
    chk("busy_v", dut.v_q, 14'h0001);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_req", mem_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_v", dut.v_q, 14'h0000);
    do_ack(8'h99);
    chk("late_v", dut.v_q, 14'h0000);
    chk("late_rbuf", dut.rbuf_q, 8'h00);
    chk("late_req", mem_req, 0);
    chk("late_rvalid", cpu_rvalid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ppu_vram_port.md
PPU_VRAM_PORT -- requirements
Module: ppu_vram_port

Interface
REQ-001 SHALL provide one clock and one reset; reset is synchronous and active-high.
REQ-002 SHALL expose the ports below:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous active-high reset
- cpu_reg  in  3  PPU register select, CPU addr[2:0]
- cpu_wr  in  1  one-cycle write strobe
- cpu_rd  in  1  one-cycle read strobe
- cpu_wdata  in  8  CPU write data
- cpu_rdata  out  8  $2007 read result
- cpu_rvalid  out  1  one-cycle pulse, cpu_rdata updated
- busy  out  1  access in flight; new $2006/$2007 strobes ignored
- mem_req  out  1  PPU memory request, held until ack
- mem_we  out  1  1 = write, 0 = read; stable while mem_req=1
- mem_addr  out  16  PPU address {2'b00, v[13:0]}, into address decoder
- mem_wdata  out  8  write data; stable while mem_req=1
- mem_rdata  in  8  read data, valid in the mem_ack cycle
- mem_ack  in  1  access complete when sampled high with mem_req=1

Function
REQ-003 SHALL hold a 14-bit address register v, write toggle w, increment select inc32 and 8-bit read buffer rbuf.
REQ-004 A write to reg 0 SHALL set inc32 to cpu_wdata[2]; other bits ignored.
REQ-005 A read of reg 2 SHALL clear w the same cycle; no other effect, including while busy.
REQ-006 A write to reg 6 with w=0 SHALL load v[13:8]=cpu_wdata[5:0] and set w=1. Bits 7:6 SHALL be dropped.
REQ-007 A write to reg 6 with w=1 SHALL load v[7:0]=cpu_wdata and clear w.
REQ-008 Increment SHALL be +1 (inc32=0) or +32 (inc32=1), modulo 2^14: 3FFF+1 gives 0000, 3FE0+32 gives 0000.
REQ-009 SHALL implement the FSM states IDLE, WR, RD, PAL2. busy=1 in every state except IDLE.
REQ-010 In IDLE, a write to reg 7 SHALL go to WR and drive mem_req=1, mem_we=1, mem_addr=v, mem_wdata=cpu_wdata from the next cycle.
REQ-011 In IDLE, a read of reg 7 with v[13:8]!=6'h3F SHALL do the following:
- the same cycle: latch cpu_rdata=rbuf and pulse cpu_rvalid next cycle
- go to RD and issue a read at v
REQ-012 In RD on ack (non-palette), SHALL load rbuf=mem_rdata, increment v and return to IDLE.
REQ-013 In IDLE, a read of reg 7 with v[13:8]==6'h3F (palette) SHALL go to RD and issue a read at v, with no immediate cpu_rvalid.
REQ-014 In RD on ack (palette), SHALL do the following:
- load cpu_rdata=mem_rdata and pulse cpu_rvalid the next cycle
- go to PAL2 and issue a read at {2'b00, v[13:12]&2'b10, v[11:0]}, i.e. v with bit 12 cleared (nametable under palette)
REQ-015 In PAL2 on ack, SHALL load rbuf=mem_rdata, increment v and return to IDLE.
REQ-016 In WR on ack, SHALL increment v and return to IDLE.
REQ-017 mem_req SHALL deassert the cycle after the ack. mem_addr, mem_we and mem_wdata SHALL stay stable from request until ack.
REQ-018 A reg 6 or reg 7 strobe while busy=1 SHALL be ignored, with no state change. A reg 0 write while busy SHALL update inc32, which is used at the pending increment.
REQ-019 cpu_wr and cpu_rd asserted together SHALL be treated as the write only.
REQ-020 cpu_rdata SHALL hold its value between cpu_rvalid pulses.
REQ-021 mem_ack without mem_req SHALL be ignored.

Reset
REQ-022 rst=1 SHALL force the following: v=0, w=0, inc32=0, rbuf=00, cpu_rdata=00, cpu_rvalid=0, busy=0, mem_req=0, mem_we=0, mem_addr=0000, mem_wdata=00, state IDLE.
REQ-023 rst mid-access SHALL abort immediately. mem_req SHALL drop the next cycle, and a later ack SHALL be ignored.

Verification
REQ-024 Address load and write: the bench SHALL cover this case.
- stimulus: reg6<=21, reg6<=08, reg7<=5A, ack after 3 cycles
- response: mem write at 2108 of 5A, then v=2109, busy low after ack
REQ-025 Buffered read: the bench SHALL cover this case.
- stimulus: v=2000, rbuf=00, memory[2000]=AB; read reg7 twice
- response: first cpu_rdata=00, second cpu_rdata=AB, v=2002
REQ-026 Palette read: the bench SHALL cover this case.
- stimulus: v=3F01, memory[3F01]=16, memory[2F01]=77; read reg7
- response: cpu_rdata=16 after first ack, then second read at 2F01, rbuf=77, v=3F02
REQ-027 Toggle and increment: the bench SHALL cover this case.
- stimulus: reg6<=3F, read reg2, reg6<=3F, reg6<=E0, reg0<=04, write reg7
- response: v=3FE0, write at 3FE0, v wraps to 0000
REQ-028 Busy and reset: the bench SHALL cover this case.
- stimulus: reg7 write with ack withheld, second reg7 write, then rst
- response: second write ignored; after rst mem_req=0, v=0000, a late ack has no effect
